// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus initiator: FSM states, rw encoding, bus width defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_bus_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  // Memory-side rw encoding: high is a read (and the idle level), low is the write strobe.
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/mem_bus_timeout.sv
// Wait-state watchdog: counts consecutive not-ready ACCESS cycles and flags the last tolerated one.
// Latency: expire is combinational on the cycle whose tick brings the count to TIMEOUT_CYCLES.
// Backpressure: none; clear has priority over tick.
module mem_bus_timeout #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expire
);

  // Count value held while the final tolerated wait cycle is in progress.
  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Restart on every new bus cycle, otherwise count wait cycles.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick) begin
      count_d = count_q + 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = tick && (count_q == LIMIT);

endmodule

// File: rtl/mem_bus_master.sv
// Core-to-memory bus initiator: one command at a time through IDLE/SETUP/ACCESS/HOLD (optional watchdog: MEM_MASTER_TIMEOUT_EN).
// Latency: response pulse 3 cycles after accept for reads, 4 for writes, plus one per wait_-high ACCESS cycle.
// Backpressure: cmd_ready is high only in IDLE; commands offered while it is low are dropped, not queued.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] addrs_bus,
  output logic              request,
  output logic              rw,
  input  logic              wait_,
  output logic [DATA_W-1:0] data_bus_write,
  input  logic [DATA_W-1:0] data_bus_read
);

  state_t            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              request_q, request_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              op_rd_q, op_rd_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic              tmo_q, tmo_d;     // write timed out; report the error from HOLD
  logic              tmo_expire;

`ifdef MEM_MASTER_TIMEOUT_EN
  mem_bus_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q == ST_SETUP),
    .tick   ((state_q == ST_ACCESS) && wait_),
    .expire (tmo_expire)
  );
`else
  // Without the watchdog ACCESS waits forever and the timeout setting has no effect.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign tmo_expire = 1'b0;
`endif

  // Next-state and next-output logic; rw only drops on the SETUP->ACCESS step of a write.
  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = cmd_ready_q;
    request_d    = request_q;
    rw_d         = rw_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    op_rd_d      = op_rd_q;
    rdata_d      = rdata_q;
    tmo_d        = tmo_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_rd_d     = cmd_rw;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          state_d     = ST_SETUP;
          cmd_ready_d = 1'b0;
          request_d   = 1'b1;
          rw_d        = RW_READ;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        rw_d    = op_rd_q ? RW_READ : RW_WRITE;
        tmo_d   = 1'b0;
      end
      ST_ACCESS: begin
        if (!wait_) begin
          if (op_rd_q) begin
            rdata_d      = data_bus_read;
            resp_valid_d = 1'b1;
            state_d      = ST_IDLE;
            request_d    = 1'b0;
            cmd_ready_d  = 1'b1;
          end else begin
            state_d = ST_HOLD;
            rw_d    = RW_READ;
          end
        end else if (tmo_expire) begin
          if (op_rd_q) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            state_d      = ST_IDLE;
            request_d    = 1'b0;
            cmd_ready_d  = 1'b1;
          end else begin
            // Abandoned writes still pass through HOLD so rw rises with address/data held.
            state_d = ST_HOLD;
            rw_d    = RW_READ;
            tmo_d   = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        resp_valid_d = 1'b1;
        resp_err_d   = tmo_q;
        state_d      = ST_IDLE;
        request_d    = 1'b0;
        cmd_ready_d  = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        request_d   = 1'b0;
        rw_d        = RW_READ;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  // State and registered outputs; reset forces rw high and request low immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cmd_ready_q  <= 1'b1;
      request_q    <= 1'b0;
      rw_q         <= RW_READ;
      addr_q       <= '0;
      wdata_q      <= '0;
      op_rd_q      <= 1'b1;
      rdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      request_q    <= request_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      op_rd_q      <= op_rd_d;
      rdata_q      <= rdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      tmo_q        <= tmo_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign request        = request_q;
  assign rw             = rw_q;
  assign addrs_bus      = addr_q;
  assign data_bus_write = wdata_q;
  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = rdata_q;
  assign resp_err       = resp_err_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: behavioural 256-word memory with programmable wait states and a response scoreboard.
// Latency: expected response edge, rw-low and request-high cycle counts are carried in each scoreboard entry.
// Backpressure: commands are offered only when cmd_ready is seen high, except the deliberate ignored-command probe.
module tb_mem_bus_master;

`ifdef MEM_MASTER_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 15;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_rw = 1'b1;
  logic [15:0] cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        cmd_ready, resp_valid, resp_err, request, rw, wait_;
  logic [15:0] resp_rdata, addrs_bus, data_bus_write, data_bus_read;

  mem_bus_master #(
    .ADDR_W(16),
    .DATA_W(16),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_rw         (cmd_rw),
    .cmd_addr       (cmd_addr),
    .cmd_wdata      (cmd_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .addrs_bus      (addrs_bus),
    .request        (request),
    .rw             (rw),
    .wait_          (wait_),
    .data_bus_write (data_bus_write),
    .data_bus_read  (data_bus_read)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] init_word(input int i);
    return (i == 4) ? 16'hABCD : ((16'(i) * 16'h0101) ^ 16'h5A5A);
  endfunction

  // ---------------- memory model ----------------
  logic [15:0] mem [256];
  logic        loaded = 1'b0;
  logic        req_prev = 1'b0;
  logic        stuck = 1'b0;
  int          acc_cnt = 0;
  int          wait_need = 0;
  int          edge_cnt = 0;

  assign data_bus_read = mem[addrs_bus[7:0]];
  assign wait_ = stuck || (request && req_prev && (acc_cnt < wait_need));

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      loaded <= 1'b1;
    end else if (request && !rw && !wait_) begin
      mem[addrs_bus[7:0]] <= data_bus_write;
    end
    req_prev <= request;
    acc_cnt  <= (request && req_prev) ? acc_cnt + 1 : 0;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          edge_at;
    int          rw0;
    int          reqc;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] ref_mem [256];
  logic [15:0] last_rd = '0;

  int          req_cnt = 0;
  int          rw0_cnt = 0;
  logic        addr_bad = 1'b0;
  logic [15:0] rec_addr = '0;
  logic [15:0] rec_data = '0;
  int          resp_seen = 0;

  task automatic handle_resp();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_resp", resp_valid, 1'b0);
      return;
    end
    e = exp_q.pop_front();
    chk("resp_rdata", resp_rdata, e.rdata);
    chk("resp_err", resp_err, e.err);
    chk("resp_latency", edge_cnt, e.edge_at);
    chk("rw_low_cycles", rw0_cnt, e.rw0);
    chk("request_cycles", req_cnt, e.reqc);
    chk("bus_stable", addr_bad, 1'b0);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      req_cnt  <= 0;
      rw0_cnt  <= 0;
      addr_bad <= 1'b0;
    end else begin
      if (resp_valid) begin
        handle_resp();
        resp_seen <= resp_seen + 1;
        req_cnt   <= 0;
        rw0_cnt   <= 0;
        addr_bad  <= 1'b0;
      end
      if (request) begin
        if (req_cnt == 0) begin
          rec_addr <= addrs_bus;
          rec_data <= data_bus_write;
        end else if (addrs_bus != rec_addr || data_bus_write != rec_data) begin
          addr_bad <= 1'b1;
        end
        req_cnt <= req_cnt + 1;
        if (!rw) rw0_cnt <= rw0_cnt + 1;
      end
    end
  end

  // Offer one command at a negedge and push its expected outcome. 'fails' marks a command
  // that must not touch memory (timed out, or aborted by reset before completion).
  task automatic issue(input logic rd, input logic [7:0] addr, input logic [15:0] wd,
                       input int waits, input logic fails);
    exp_t e;
    int   n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_wait", cmd_ready, 1'b1);
      return;
    end
    if (rd && !fails) last_rd = ref_mem[addr];
    if (!rd && !fails) ref_mem[addr] = wd;
    e.rdata   = last_rd;
    e.err     = fails;
    e.edge_at = edge_cnt + (rd ? 3 : 4) + waits;
    e.rw0     = rd ? 0 : waits + 1;
    e.reqc    = (rd ? 2 : 3) + waits;
    exp_q.push_back(e);
    wait_need = stuck ? 0 : waits;
    cmd_valid = 1'b1;
    cmd_rw    = rd;
    cmd_addr  = {8'h00, addr};
    cmd_wdata = wd;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int          seen0;
    logic        rd_r;
    logic [7:0]  a_r;
    logic [15:0] wd_r;
    int          w_r;

    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_request", request, 1'b0);
    chk("rst_rw", rw, 1'b1);
    chk("rst_addrs_bus", addrs_bus, 16'h0000);
    chk("rst_data_bus_write", data_bus_write, 16'h0000);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 16'h0000);
    chk("rst_resp_err", resp_err, 1'b0);
    #2 reset = 1'b0;
    @(negedge clk);

    // Plain read of the preloaded word.
    issue(1'b1, 8'h04, 16'h0000, 0, 1'b0);
    drain();

    // Write then read the same word back-to-back.
    issue(1'b0, 8'h10, 16'h1234, 0, 1'b0);
    issue(1'b1, 8'h10, 16'h0000, 0, 1'b0);
    drain();
    chk("mem_after_write", mem[8'h10], 16'h1234);

    // Wait states on a read and on a write.
    issue(1'b1, 8'h21, 16'h0000, 3, 1'b0);
    drain();
    issue(1'b0, 8'h30, 16'hBEEF, 2, 1'b0);
    drain();
    chk("mem_after_wait_write", mem[8'h30], 16'hBEEF);

    // A command offered during SETUP must be dropped.
    seen0 = resp_seen;
    issue(1'b1, 8'h22, 16'h0000, 0, 1'b0);
    chk("ready_low_in_setup", cmd_ready, 1'b0);
    cmd_valid = 1'b1;
    cmd_rw    = 1'b0;
    cmd_addr  = 16'h0020;
    cmd_wdata = 16'hDEAD;
    @(negedge clk);
    cmd_valid = 1'b0;
    drain();
    chk("single_resp", resp_seen - seen0, 1);
    chk("ignored_write_mem", mem[8'h20], ref_mem[8'h20]);

    // Random back-to-back mix over a small address window.
    for (int i = 0; i < 8; i++) begin
      rd_r = 1'($urandom_range(0, 1));
      a_r  = 8'($urandom_range(64, 71));
      wd_r = 16'($urandom);
      w_r  = $urandom_range(0, 2);
      issue(rd_r, a_r, wd_r, w_r, 1'b0);
    end
    drain();

`ifdef MEM_MASTER_TIMEOUT_EN
    // Watchdog: stuck wait_ on a read and on a write.
    stuck = 1'b1;
    issue(1'b1, 8'h05, 16'h0000, TMO - 1, 1'b1);
    drain();
    chk("tmo_rd_ready", cmd_ready, 1'b1);
    issue(1'b0, 8'h06, 16'h7777, TMO - 1, 1'b1);
    drain();
    stuck = 1'b0;
    chk("tmo_wr_rw_idle", rw, 1'b1);
    chk("tmo_wr_mem", mem[8'h06], ref_mem[8'h06]);
`endif

    // Reset while a write sits in ACCESS.
    stuck = 1'b1;
    issue(1'b0, 8'h50, 16'h5555, 0, 1'b1);
    @(negedge clk);
    chk("abort_pre_rw_low", rw, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("abort_rw_async", rw, 1'b1);
    chk("abort_request_async", request, 1'b0);
    stuck = 1'b0;
    seen0 = resp_seen;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    last_rd = '0;
    repeat (8) @(negedge clk);
    chk("abort_no_resp", resp_seen - seen0, 0);
    chk("abort_mem_unchanged", mem[8'h50], ref_mem[8'h50]);
    chk("abort_rdata_reset", resp_rdata, last_rd);
    chk("abort_ready", cmd_ready, 1'b1);

    // Bus still usable after the abort.
    issue(1'b1, 8'h04, 16'h0000, 1, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Bus initiator that sits between the CPU core and the 256-word instruction/data memory, converting single-cycle core load/store commands into the memory's request/rw/wait_ protocol. It owns the address and write-data buses, guarantees `rw` never falls to write with unstable address or data, and returns read data or write completion to the core with a one-cycle response pulse.

## Interface
- `ADDR_W`, 16, address bus width
- `DATA_W`, 16, data bus width
- `TIMEOUT_CYCLES`, 15, max consecutive `wait_`-high cycles tolerated in ACCESS (used only with the macro); range 1..255
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `cmd_valid`  in  1  core issues a command
- `cmd_ready`  out  1  master accepts a command this cycle
- `cmd_rw`  in  1  1 = read, 0 = write (memory encoding)
- `cmd_addr`  in  ADDR_W  target address
- `cmd_wdata`  in  DATA_W  store data
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  DATA_W  read data, valid with `resp_valid` on reads
- `resp_err`  out  1  timeout flag, valid with `resp_valid`
- `addrs_bus`  out  ADDR_W  to memory
- `request`  out  1  to memory
- `rw`  out  1  to memory; 1 read, 0 write
- `wait_`  in  1  from memory; 1 = not ready
- `data_bus_write`  out  DATA_W  to memory
- `data_bus_read`  in  DATA_W  from memory

## Operation
- FSM states: IDLE, SETUP, ACCESS, HOLD.
- IDLE: `cmd_ready`=1; `request`=0, `rw`=1. On `cmd_valid`: latch rw/addr/wdata, go SETUP.
- SETUP: drive latched `addrs_bus`, `data_bus_write`; `request`=1; `rw`=1 always. Go ACCESS.
- ACCESS read: `rw`=1; if `wait_`=0, capture `data_bus_read` into `resp_rdata`, pulse `resp_valid`, go IDLE; else stay.
- ACCESS write: `rw`=0 (write strobe); if `wait_`=0 go HOLD; else stay with `rw`=0.
- HOLD (write only): `rw`=1, address/data still held; pulse `resp_valid`, go IDLE.
- `rw` is 1 in every state except ACCESS-write; address and write data never change while `rw`=0.
- `addrs_bus`, `data_bus_write` retain last values in IDLE (no glitching to 0).
- Commands while `cmd_ready`=0 are ignored, not queued.
- `resp_rdata` holds last read value until the next read completes; writes leave it unchanged.

## Timing
- All outputs registered. Reset values: `cmd_ready`=1, `request`=0, `rw`=1, `addrs_bus`=0, `data_bus_write`=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, state IDLE.
- Read latency with `wait_`=0: accept at edge 0, `resp_valid` high in cycle 3; write: cycle 4. Each `wait_`-high cycle in ACCESS adds one.
- `resp_valid` and `cmd_ready` both high in the response cycle; a command accepted then starts back-to-back.
- Reset mid-operation: `rw` returns to 1 and `request` to 0 asynchronously; aborted command produces no response.

## Configuration
- `MEM_MASTER_TIMEOUT_EN` defined: 8-bit counter clears on SETUP entry, increments per ACCESS cycle with `wait_`=1; on reaching `TIMEOUT_CYCLES` the FSM leaves ACCESS (writes via HOLD so `rw` returns to 1), pulses `resp_valid` with `resp_err`=1, `resp_rdata` unchanged.
- Undefined: no counter; ACCESS waits indefinitely; `resp_err` tied 0.

## Structure
- Package `mem_bus_pkg`: FSM state enum, `RW_READ`=1'b1, `RW_WRITE`=1'b0, `ADDR_W`/`DATA_W` defaults.
- One sub-module `mem_bus_timeout` (counter + compare), instantiated only under the macro.

## Test plan
- Read 0x0004 against preloaded memory -> `resp_valid` in cycle 3, `resp_rdata`=0xABCD, `resp_err`=0.
- Write 0x1234 to 0x0010, then read 0x0010 back-to-back -> `rw`=0 for exactly one cycle, address stable throughout; read returns 0x1234.
- Read with `wait_` forced high 3 ACCESS cycles -> `resp_valid` in cycle 6, `request` held high throughout.
- `cmd_valid` pulsed during SETUP -> ignored, exactly one `resp_valid`.
- Assert `reset` during ACCESS of a write -> `rw`=1 and `request`=0 within the same cycle, no `resp_valid`, target word unchanged.
- With `MEM_MASTER_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, `wait_` stuck high -> `resp_valid` with `resp_err`=1 after 4 ACCESS cycles, FSM back in IDLE.
